floating_point_multiplier: RTL and testbench

//   Pipelined IEEE-754 binary16 multiplier; product stage of the TTPU MAC lane.

---
 rtl/floating_point_multiplier.sv | 158 +++++++++++++++
 tb/tb_floating_point_multiplier.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_multiplier.sv
// Three-stage pipelined binary16 multiplier for the MAC lane: unpack/classify,
// significand product, then normalise, truncate and pack. en stalls every stage.
module floating_point_multiplier #(
  parameter int DATA_WIDTH = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int MAN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  out_valid
);

  localparam int SIG_WIDTH  = MAN_WIDTH + 1;
  localparam int PROD_WIDTH = 2 * SIG_WIDTH;
  localparam int SEXP_WIDTH = EXP_WIDTH + 2;

  localparam logic [EXP_WIDTH-1:0]         EXP_ALL_ONES = '1;
  localparam logic signed [SEXP_WIDTH-1:0] EXP_BIAS     = SEXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [SEXP_WIDTH-1:0] EXP_LIMIT    = SEXP_WIDTH'((1 << EXP_WIDTH) - 1);
  localparam logic signed [SEXP_WIDTH-1:0] EXP_ZERO     = '0;
  localparam logic signed [SEXP_WIDTH-1:0] EXP_ONE      = SEXP_WIDTH'(1);

  localparam logic [DATA_WIDTH-1:0] QNAN_WORD = {1'b0, EXP_ALL_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    KIND_NORMAL,
    KIND_ZERO,
    KIND_INF,
    KIND_NAN
  } productKind_e;

  logic [EXP_WIDTH-1:0] expA, expB;
  logic [MAN_WIDTH-1:0] fracA, fracB;
  logic                 zeroA, zeroB, infA, infB, nanA, nanB;
  logic signed [SEXP_WIDTH-1:0] expSumComb;
  productKind_e         kindComb;

  assign expA  = a[DATA_WIDTH-2 -: EXP_WIDTH];
  assign expB  = b[DATA_WIDTH-2 -: EXP_WIDTH];
  assign fracA = a[MAN_WIDTH-1:0];
  assign fracB = b[MAN_WIDTH-1:0];

  // A zero exponent field counts as zero whatever the fraction, so subnormals flush here.
  assign zeroA = (expA == '0);
  assign zeroB = (expB == '0);
  assign infA  = (expA == EXP_ALL_ONES) && (fracA == '0);
  assign infB  = (expB == EXP_ALL_ONES) && (fracB == '0);
  assign nanA  = (expA == EXP_ALL_ONES) && (fracA != '0);
  assign nanB  = (expB == EXP_ALL_ONES) && (fracB != '0);

  assign expSumComb = $signed({2'b00, expA}) + $signed({2'b00, expB}) - EXP_BIAS;

  // Special-case priority: NaN (including inf x zero) beats inf beats zero.
  always_comb begin
    kindComb = KIND_NORMAL;
    if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
      kindComb = KIND_NAN;
    end else if (infA || infB) begin
      kindComb = KIND_INF;
    end else if (zeroA || zeroB) begin
      kindComb = KIND_ZERO;
    end
  end

  logic                         s1Valid;
  logic                         s1Sign;
  productKind_e                 s1Kind;
  logic signed [SEXP_WIDTH-1:0] s1Exp;
  logic [SIG_WIDTH-1:0]         s1SigA, s1SigB;

  // Stage 1: capture the unpacked operands with hidden bits restored.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Sign  <= 1'b0;
      s1Kind  <= KIND_NORMAL;
      s1Exp   <= '0;
      s1SigA  <= '0;
      s1SigB  <= '0;
    end else if (en) begin
      s1Valid <= in_valid;
      s1Sign  <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
      s1Kind  <= kindComb;
      s1Exp   <= expSumComb;
      s1SigA  <= {1'b1, fracA};
      s1SigB  <= {1'b1, fracB};
    end
  end

  logic                         s2Valid;
  logic                         s2Sign;
  productKind_e                 s2Kind;
  logic signed [SEXP_WIDTH-1:0] s2Exp;
  logic [PROD_WIDTH-1:0]        s2Prod;

  // Stage 2: full-width significand product, value in [1,4) with binary point below bit PROD_WIDTH-2.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Sign  <= 1'b0;
      s2Kind  <= KIND_NORMAL;
      s2Exp   <= '0;
      s2Prod  <= '0;
    end else if (en) begin
      s2Valid <= s1Valid;
      s2Sign  <= s1Sign;
      s2Kind  <= s1Kind;
      s2Exp   <= s1Exp;
      s2Prod  <= PROD_WIDTH'(s1SigA) * PROD_WIDTH'(s1SigB);
    end
  end

  logic signed [SEXP_WIDTH-1:0] normExp;
  logic [MAN_WIDTH-1:0]         normFrac;
  logic [DATA_WIDTH-1:0]        packedComb;

  // Normalise by at most one place and drop the low bits (round toward zero).
  always_comb begin
    normExp    = s2Exp;
    normFrac   = s2Prod[PROD_WIDTH-3 -: MAN_WIDTH];
    packedComb = '0;
    if (s2Prod[PROD_WIDTH-1]) begin
      normExp  = s2Exp + EXP_ONE;
      normFrac = s2Prod[PROD_WIDTH-2 -: MAN_WIDTH];
    end
    case (s2Kind)
      KIND_NAN:  packedComb = QNAN_WORD;
      KIND_INF:  packedComb = {s2Sign, EXP_ALL_ONES, {MAN_WIDTH{1'b0}}};
      KIND_ZERO: packedComb = {s2Sign, {(DATA_WIDTH-1){1'b0}}};
      default: begin
        if (normExp >= EXP_LIMIT) begin
          packedComb = {s2Sign, EXP_ALL_ONES, {MAN_WIDTH{1'b0}}};
        end else if (normExp <= EXP_ZERO) begin
          packedComb = {s2Sign, {(DATA_WIDTH-1){1'b0}}};
        end else begin
          packedComb = {s2Sign, normExp[EXP_WIDTH-1:0], normFrac};
        end
      end
    endcase
  end

  // Stage 3: registered output; bubbles still update result but never assert out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      result    <= packedComb;
      out_valid <= s2Valid;
    end
  end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Scoreboard bench for floating_point_multiplier: expected products are queued as
// pairs are issued and retired as the pipeline advances.
module tb_floating_point_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [15:0] value;
  } expect_t;

  expect_t     sbQueue[$];
  logic        lastValid;
  logic [15:0] lastResult;

  always #5 clk = ~clk;

  floating_point_multiplier #(
    .DATA_WIDTH(16),
    .EXP_WIDTH (5),
    .MAN_WIDTH (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .result   (result),
    .out_valid(out_valid)
  );

  // Reference product computed in real arithmetic, truncated toward zero.
  function automatic logic [15:0] modelMul(input logic [15:0] x, input logic [15:0] y);
    logic s;
    int   ex, ey, fx, fy, e;
    logic zx, zy, ix, iy, nx, ny;
    real  m;
    s  = x[15] ^ y[15];
    ex = 32'(x[14:10]);
    ey = 32'(y[14:10]);
    fx = 32'(x[9:0]);
    fy = 32'(y[9:0]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 31) && (fx == 0);
    iy = (ey == 31) && (fy == 0);
    nx = (ex == 31) && (fx != 0);
    ny = (ey == 31) && (fy != 0);
    if (nx || ny || (ix && zy) || (zx && iy)) return 16'h7E00;
    if (ix || iy) return {s, 5'h1F, 10'h000};
    if (zx || zy) return {s, 15'h0000};
    m = (1.0 + fx / 1024.0) * (1.0 + fy / 1024.0);
    e = ex + ey - 30;
    while (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    if (e + 15 >= 31) return {s, 5'h1F, 10'h000};
    if (e + 15 <= 0) return {s, 15'h0000};
    return {s, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  // Drive one cycle; on an advancing edge queue the new slot and retire the oldest one.
  task automatic applyStimulus(input logic enIn, input logic validIn,
                               input logic [15:0] aIn, input logic [15:0] bIn,
                               input logic [15:0] expIn,
                               output logic expValid, output logic [15:0] expResult);
    expect_t entry;
    en       = enIn;
    in_valid = validIn;
    a        = aIn;
    b        = bIn;
    @(posedge clk);
    if (enIn) begin
      entry.valid = validIn;
      entry.value = expIn;
      sbQueue.push_back(entry);
      entry      = sbQueue.pop_front();
      lastValid  = entry.valid;
      lastResult = entry.value;
    end
    #1;
    expValid  = lastValid;
    expResult = lastResult;
  endtask

  task automatic doReset(input logic enDuring);
    expect_t idle;
    reset    = 1'b1;
    en       = enDuring;
    in_valid = 1'b1;
    a        = 16'h4200;
    b        = 16'hC600;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbQueue.delete();
    idle.valid = 1'b0;
    idle.value = 16'h0000;
    sbQueue.push_back(idle);
    sbQueue.push_back(idle);
    lastValid  = 1'b0;
    lastResult = 16'h0000;
  endtask

  task automatic test_reset();
    logic        ev;
    logic [15:0] er;
    doReset(1'b1);
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_result: got %h expected 0000", result);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL reset_idle[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
    end
  endtask

  task automatic test_single();
    logic        ev;
    logic [15:0] er;
    int          seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) applyStimulus(1'b1, 1'b1, 16'h4200, 16'hC600, 16'hCC80, ev, er);
      else        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL single[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        seen++;
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL single[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("[TB] FAIL single_count: got %0d expected 1", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta[7] = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C01, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tb[7] = '{16'h3C00, 16'h4000, 16'h4400, 16'h3C01, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tx[7] = '{16'h3C00, 16'h4400, 16'h4000, 16'h3C02, 16'h0000, 16'h0000, 16'h0000};
    logic        ev;
    logic [15:0] er;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, (i < 4), ta[i], tb[i], tx[i], ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL b2b[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] ta[9] = '{16'h7BFF, 16'h0400, 16'h7E00, 16'h7C00, 16'h8000, 16'hFC00, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tb[9] = '{16'h7BFF, 16'h0400, 16'h3C00, 16'h0000, 16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] tx[9] = '{16'h7C00, 16'h0000, 16'h7E00, 16'h7E00, 16'h8000, 16'hFC00, 16'h0000, 16'h0000, 16'h0000};
    logic        ev;
    logic [15:0] er;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, (i < 6), ta[i], tb[i], tx[i], ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL specials[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL specials[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        ev;
    logic [15:0] er;
    int          seen = 0;
    applyStimulus(1'b1, 1'b1, 16'h3C00, 16'h4000, 16'h4000, ev, er);
    applyStimulus(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h4400, ev, er);
    for (int i = 0; i < 11; i++) begin
      if (i == 0)     applyStimulus(1'b1, 1'b1, 16'h4200, 16'hC600, 16'hCC80, ev, er);
      else if (i < 6) applyStimulus(1'b0, 1'b1, 16'h5555, 16'h4444, 16'hFFFF, ev, er);
      else            applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL stall[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        if (en) seen++;
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL stall[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("[TB] FAIL stall_count: got %0d expected 3", seen);
    end
  endtask

  task automatic test_reset_midflight();
    logic        ev;
    logic [15:0] er;
    applyStimulus(1'b1, 1'b1, 16'h4200, 16'hC600, 16'hCC80, ev, er);
    applyStimulus(1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00, ev, er);
    doReset(1'b0);
    checks++;
    if (result !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midreset_result: got %h expected 0000", result);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_out_valid: got %b expected 0", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL midreset_drain[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
    end
  endtask

  task automatic test_bubbles();
    logic        ev;
    logic [15:0] er;
    logic [15:0] opA;
    for (int i = 0; i < 13; i++) begin
      opA = 16'h3C00 + 16'(i);
      applyStimulus(1'b1, (i < 10) && (i % 2 == 0), opA, 16'h4000, modelMul(opA, 16'h4000), ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL bubbles[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL bubbles[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        ev;
    logic [15:0] er;
    logic [15:0] ra, rb;
    logic        ren, rvalid;
    for (int i = 0; i < 10003; i++) begin
      ra     = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      rb     = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      ren    = (i >= 10000) || ($urandom_range(0, 9) != 0);
      rvalid = (i < 10000) && ($urandom_range(0, 3) != 0);
      applyStimulus(ren, rvalid, ra, rb, modelMul(ra, rb), ev, er);
      checks++;
      if (out_valid !== ev) begin
        failures++;
        $display("[TB] FAIL random[%0d] out_valid: got %b expected %b", i, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (result !== er) begin
          failures++;
          $display("[TB] FAIL random[%0d] result: got %h expected %h", i, result, er);
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    in_valid   = 1'b0;
    a          = 16'h0000;
    b          = 16'h0000;
    lastValid  = 1'b0;
    lastResult = 16'h0000;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_specials();
    test_stall();
    test_reset_midflight();
    test_bubbles();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
